// File: rtl/seq_pkg.sv
// Shared types and default sizing for the stage sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int unsigned DEF_NUM_STAGES = 5;
    localparam int unsigned DEF_NUM_INSTR  = 1024;

endpackage

// File: rtl/stage_token_shift.sv
// Token shift register: one bit per pipeline stage, held on stall, and
// presented as stage enables that are forced to zero while stalled.
module stage_token_shift
    import seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  in_bit,
    input  logic                  stall,
    output logic [NUM_STAGES-1:0] tok,
    output logic [NUM_STAGES-1:0] tok_next,
    output logic [NUM_STAGES-1:0] stage_en
);

    assign tok_next = {tok[NUM_STAGES-2:0], in_bit};
    assign stage_en = stall ? '0 : tok;

    always_ff @(posedge clk) begin
        if (rst) begin
            tok <= '0;
        end else if (load) begin
            tok <= NUM_STAGES'(1);
        end else if (advance && !stall) begin
            tok <= tok_next;
        end
    end

endmodule

// File: rtl/stage_seq_ctrl.sv
// Pipeline stage sequencer: fills, runs and drains NUM_INSTR instructions
// through NUM_STAGES stages. Define SEQ_PERF_CNT_EN to add stall_cycles.
module stage_seq_ctrl
    import seq_pkg::*;
#(
    parameter  int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter  int unsigned NUM_INSTR  = DEF_NUM_INSTR,
    localparam int unsigned IDX_W      = $clog2(NUM_INSTR + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [IDX_W-1:0]      issue_idx,
    output logic                  busy,
    output logic                  done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INSTR);

    seq_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [NUM_STAGES-1:0] tok;
    logic [NUM_STAGES-1:0] tok_next;
    logic                  in_bit;
    logic                  load;

    // The instruction in stage 0 counts as issued when the token moves on;
    // a new token enters only while instructions remain.
    assign idx_next  = (tok[0] && idx != LAST) ? idx + IDX_W'(1) : idx;
    assign in_bit    = (idx_next != LAST);
    assign load      = (state == IDLE) && start;
    assign issue_idx = idx;

    stage_token_shift #(
        .NUM_STAGES(NUM_STAGES)
    ) u_token (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (busy),
        .in_bit  (in_bit),
        .stall   (stall),
        .tok     (tok),
        .tok_next(tok_next),
        .stage_en(stage_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FILL, RUN, DRAIN: begin
                    if (!stall) begin
                        idx <= idx_next;
                        // Next-state is judged on the register contents after this shift.
                        if (tok_next == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!tok_next[0]) begin
                            state <= DRAIN;
                        end else if (&tok_next) begin
                            state <= RUN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (load) begin
            stall_cycles <= '0;
        end else if (busy && stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stage_seq_ctrl.sv
// Self-checking bench for stage_seq_ctrl; two instances (8 and 2 instructions)
// share inputs, and each scenario compares the selected one to a stage-window model.
module tb_stage_seq_ctrl;

    localparam int NS   = 5;
    localparam int NI_A = 8;
    localparam int NI_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;

    logic [NS-1:0] en_a, en_b;
    logic [3:0]    idx_a;
    logic [1:0]    idx_b;
    logic          busy_a, busy_b, done_a, done_b;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]   sc_a, sc_b;
`endif

    int total = 0;
    int bad   = 0;
    bit sel_b = 1'b0;

    always #5 clk = ~clk;

    stage_seq_ctrl #(.NUM_STAGES(NS), .NUM_INSTR(NI_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .stage_en(en_a), .issue_idx(idx_a), .busy(busy_a), .done(done_a)
`ifdef SEQ_PERF_CNT_EN
        , .stall_cycles(sc_a)
`endif
    );

    stage_seq_ctrl #(.NUM_STAGES(NS), .NUM_INSTR(NI_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .stage_en(en_b), .issue_idx(idx_b), .busy(busy_b), .done(done_b)
`ifdef SEQ_PERF_CNT_EN
        , .stall_cycles(sc_b)
`endif
    );

    logic [NS-1:0] o_en;
    int            o_idx;
    logic          o_busy, o_done;
    logic [31:0]   o_sc;

    always_comb begin
        o_en   = sel_b ? en_b : en_a;
        o_idx  = sel_b ? int'(idx_b) : int'(idx_a);
        o_busy = sel_b ? busy_b : busy_a;
        o_done = sel_b ? done_b : done_a;
        o_sc   = '0;
`ifdef SEQ_PERF_CNT_EN
        o_sc   = sel_b ? sc_b : sc_a;
`endif
    end

    // Stage s works on instruction k-s during active cycle k, if that instruction exists.
    function automatic logic [NS-1:0] exp_en(input int k, input int ni);
        logic [NS-1:0] e;
        e = '0;
        for (int s = 0; s < NS; s++) begin
            e[s] = (k - s >= 0) && (k - s < ni);
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Starts a run from IDLE; mode 0 = no stall, 1 = random stalls, 2 = two stalls at k=5.
    task automatic do_run(input int ni, input int mode, input bit hold, input string nm);
        int k, cyc, nstall, limit;
        logic [NS-1:0] want;
        int want_idx;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        k = 0; cyc = 0; nstall = 0;
        limit = 4 * (ni + NS) + 40;
        while (k < ni + NS - 1 && cyc < limit) begin
            bit s;
            s = 1'b0;
            if (mode == 1) s = ($urandom_range(0, 3) == 0);
            if (mode == 2 && k == 5 && nstall < 2) s = 1'b1;
            stall = s;
            want = s ? '0 : exp_en(k, ni);
            want_idx = (k < ni) ? k : ni;
            @(negedge clk);
            total++;
            if (o_en !== want) begin
                bad++;
                $display("FAIL %s stage_en k=%0d stall=%0d got=%b want=%b", nm, k, s, o_en, want);
            end
            total++;
            if (o_idx !== want_idx) begin
                bad++;
                $display("FAIL %s issue_idx k=%0d got=%0d want=%0d", nm, k, o_idx, want_idx);
            end
            total++;
            if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                bad++;
                $display("FAIL %s busy/done k=%0d got=%b/%b want=1/0", nm, k, o_busy, o_done);
            end
            @(posedge clk); #1;
            if (s) nstall++;
            else k++;
            cyc++;
        end
        total++;
        if (cyc >= limit) begin
            bad++;
            $display("FAIL %s timeout after %0d cycles", nm, cyc);
        end
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_en !== '0 || o_idx !== ni) begin
            bad++;
            $display("FAIL %s done_cycle got done=%b busy=%b en=%b idx=%0d want 1/0/0/%0d",
                     nm, o_done, o_busy, o_en, o_idx, ni);
        end
`ifdef SEQ_PERF_CNT_EN
        total++;
        if (o_sc !== 32'(nstall)) begin
            bad++;
            $display("FAIL %s stall_cycles got=%0d want=%0d", nm, o_sc, nstall);
        end
`endif
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_en !== '0) begin
            bad++;
            $display("FAIL %s idle_after got done=%b busy=%b en=%b want 0/0/0", nm, o_done, o_busy, o_en);
        end
`ifdef SEQ_PERF_CNT_EN
        total++;
        if (o_sc !== 32'(nstall)) begin
            bad++;
            $display("FAIL %s stall_cycles_hold got=%0d want=%0d", nm, o_sc, nstall);
        end
`endif
    endtask

    task automatic test_reset();
        sel_b = 1'b0;
        rst = 1'b1; start = 1'b1; stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (o_en !== '0 || o_idx !== 0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got en=%b idx=%0d busy=%b done=%b want 0/0/0/0", o_en, o_idx, o_busy, o_done);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (o_en !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                bad++;
                $display("FAIL idle_stall got en=%b busy=%b done=%b want 0/0/0", o_en, o_busy, o_done);
            end
        end
        stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_no_stall();
        sel_b = 1'b0;
        do_reset();
        do_run(NI_A, 0, 1'b0, "nostall");
    endtask

    task automatic test_stall_run();
        sel_b = 1'b0;
        do_reset();
        do_run(NI_A, 2, 1'b0, "stall_run");
    endtask

    task automatic test_short();
        sel_b = 1'b1;
        do_reset();
        do_run(NI_B, 0, 1'b0, "short");
        do_run(NI_B, 1, 1'b0, "short_rand");
    endtask

    task automatic test_random_stalls();
        sel_b = 1'b0;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            do_run(NI_A, 1, 1'b0, "rand");
        end
    endtask

    task automatic test_mid_reset();
        sel_b = 1'b0;
        do_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (o_en !== 5'b00111 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre got en=%b busy=%b want 00111/1", o_en, o_busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (o_en !== '0 || o_idx !== 0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_post got en=%b idx=%0d busy=%b done=%b want 0/0/0/0",
                         o_en, o_idx, o_busy, o_done);
            end
            @(posedge clk); #1;
        end
        do_run(NI_A, 0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        sel_b = 1'b0;
        do_reset();
        do_run(NI_A, 0, 1'b1, "b2b_first");
        do_run(NI_A, 1, 1'b1, "b2b_second");
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_stall_run();
        test_short();
        test_random_stalls();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
